// File: rtl/axi_b_alloc_pkg.sv
// Shared types and constants for the AXI write-response allocator.
// Holds the allocator FSM encoding and the standard BRESP codes.
package axi_b_alloc_pkg;

    typedef enum logic {
        ST_OPERATIVE  = 1'b0,
        ST_ERROR_RESP = 1'b1
    } alloc_state_e;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_rr_arb_hold.sv
// Round-robin arbiter whose grant is frozen while the winner waits for ready.
// The pointer advances past the winner only when a handshake completes.
module axi_rr_arb_hold #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [N-1:0]     req_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [N-1:0]     grant_o,
    output logic             hold_o
);

    localparam logic [IDX_W:0] N_C = (IDX_W+1)'(N);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_hold_idx;
    logic             r_hold;

    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_idx;
    logic             w_valid;
    logic             w_hs;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W:0]   b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + b;
        if (s >= N_C) begin
            s = s - N_C;
        end
        return s[IDX_W-1:0];
    endfunction

    // Descending scan so the candidate closest to the pointer is written last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[wrap_add(r_ptr, (IDX_W+1)'(k))]) begin
                w_found = 1'b1;
                w_pick  = wrap_add(r_ptr, (IDX_W+1)'(k));
            end
        end
    end

    assign w_idx   = r_hold ? r_hold_idx : w_pick;
    assign w_valid = en_i && (r_hold ? req_i[r_hold_idx] : w_found);
    assign w_hs    = w_valid && ready_i;

    assign valid_o = w_valid;
    assign idx_o   = w_idx;
    assign hold_o  = r_hold;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant_o[gi] = w_valid && (w_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
        end else begin
            if (w_hs) begin
                r_ptr  <= wrap_add(w_idx, (IDX_W+1)'(1));
                r_hold <= 1'b0;
            end else if (w_valid) begin
                r_hold     <= 1'b1;
                r_hold_idx <= w_idx;
            end
        end
    end

endmodule

// File: rtl/axi_b_allocator_rr.sv
// Merges B responses from several downstream ports onto one master port and
// injects queued error responses once no writes remain outstanding.
module axi_b_allocator_rr
    import axi_b_alloc_pkg::*;
#(
    parameter int         AXI_USER_W  = 6,
    parameter int         N_INIT_PORT = 4,
    parameter int         AXI_ID_IN   = 16,
    parameter int         AXI_ID_OUT  = AXI_ID_IN + 3,
    parameter int         CNT_W       = 10,
    parameter int         ERR_DEPTH   = 4,
    parameter logic [1:0] ERR_RESP    = BRESP_DECERR
) (
    input  logic                                   clk,
    input  logic                                   rst_n,

    input  logic [N_INIT_PORT-1:0][AXI_ID_OUT-1:0] bid_i,
    input  logic [N_INIT_PORT-1:0][1:0]            bresp_i,
    input  logic [N_INIT_PORT-1:0][AXI_USER_W-1:0] buser_i,
    input  logic [N_INIT_PORT-1:0]                 bvalid_i,
    output logic [N_INIT_PORT-1:0]                 bready_o,

    output logic [AXI_ID_IN-1:0]                   bid_o,
    output logic [1:0]                             bresp_o,
    output logic [AXI_USER_W-1:0]                  buser_o,
    output logic                                   bvalid_o,
    input  logic                                   bready_i,

    input  logic                                   incr_req_i,
    output logic                                   full_counter_o,
    output logic                                   outstanding_trans_o,

    input  logic                                   error_req_i,
    input  logic [AXI_ID_IN-1:0]                   error_id_i,
    input  logic [AXI_USER_W-1:0]                  error_user_i,
    output logic                                   error_gnt_o,
    output logic                                   error_full_o
);

    localparam int IDX_W = idx_width(N_INIT_PORT);
    localparam int QA_W  = $clog2(ERR_DEPTH);
    localparam int QE_W  = AXI_ID_IN + AXI_USER_W;
    localparam logic [QA_W:0] Q_DEPTH_C = (QA_W+1)'(ERR_DEPTH);

    alloc_state_e     r_state;
    alloc_state_e     w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [QE_W-1:0]  r_q_mem [ERR_DEPTH];
    logic [QA_W-1:0]  r_q_wr;
    logic [QA_W-1:0]  r_q_rd;
    logic [QA_W:0]    r_q_cnt;

    logic                   w_op;
    logic                   w_arb_valid;
    logic [IDX_W-1:0]       w_arb_idx;
    logic [N_INIT_PORT-1:0] w_arb_grant;
    logic                   w_arb_hold;
    logic                   w_arb_hs;
    logic                   w_err_pop;
    logic                   w_q_full;
    logic                   w_q_empty;
    logic                   w_q_push;
    logic                   w_cnt_zero;
    logic                   w_cnt_full;
    logic [QE_W-1:0]        w_q_head;
    logic [N_INIT_PORT-1:0] w_unused_id_hi;

    assign w_op = (r_state == ST_OPERATIVE);

    generate
        if (N_INIT_PORT == 1) begin : g_bypass
            assign w_arb_valid = bvalid_i[0];
            assign w_arb_idx   = '0;
            assign w_arb_grant = '1;
            assign w_arb_hold  = 1'b0;
        end else begin : g_arb
            axi_rr_arb_hold #(
                .N     (N_INIT_PORT),
                .IDX_W (IDX_W)
            ) u_arb (
                .clk     (clk),
                .rst_n   (rst_n),
                .en_i    (w_op),
                .req_i   (bvalid_i),
                .ready_i (bready_i),
                .valid_o (w_arb_valid),
                .idx_o   (w_arb_idx),
                .grant_o (w_arb_grant),
                .hold_o  (w_arb_hold)
            );
        end
    endgenerate

    // Upstream IDs carry routing bits above AXI_ID_IN that the master never sees.
    generate
        for (genvar gi = 0; gi < N_INIT_PORT; gi++) begin : g_id_hi
            if (AXI_ID_OUT > AXI_ID_IN) begin : g_hi
                assign w_unused_id_hi[gi] = ^bid_i[gi][AXI_ID_OUT-1:AXI_ID_IN];
            end else begin : g_none
                assign w_unused_id_hi[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_arb_hs   = w_op && w_arb_valid && bready_i;
    assign w_err_pop  = !w_op && bready_i;
    assign w_q_full   = (r_q_cnt == Q_DEPTH_C);
    assign w_q_empty  = (r_q_cnt == '0);
    assign w_q_push   = error_req_i && !w_q_full;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_full = &r_cnt;
    assign w_q_head   = r_q_mem[r_q_rd];

    // Outstanding-write counter; a simultaneous issue and completion cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (incr_req_i && !w_arb_hs && !w_cnt_full) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_arb_hs && !incr_req_i && !w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_q_push) begin
            r_q_mem[r_q_wr] <= {error_id_i, error_user_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_q_cnt <= '0;
        end else begin
            if (w_q_push) begin
                r_q_wr <= r_q_wr + QA_W'(1);
            end
            if (w_err_pop) begin
                r_q_rd <= r_q_rd + QA_W'(1);
            end
            if (w_q_push && !w_err_pop) begin
                r_q_cnt <= r_q_cnt + (QA_W+1)'(1);
            end else if (!w_q_push && w_err_pop) begin
                r_q_cnt <= r_q_cnt - (QA_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OPERATIVE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Errors are only injected into an idle channel so they never interleave
    // with a real response that is still owed to the master.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OPERATIVE: begin
                if (!w_q_empty && w_cnt_zero && !w_arb_hold && !w_arb_valid) begin
                    w_state_next = ST_ERROR_RESP;
                end
            end
            ST_ERROR_RESP: begin
                if (bready_i && !((r_q_cnt > (QA_W+1)'(1)) && w_cnt_zero)) begin
                    w_state_next = ST_OPERATIVE;
                end
            end
            default: w_state_next = ST_OPERATIVE;
        endcase
    end

    always_comb begin
        bvalid_o = w_arb_valid;
        bid_o    = bid_i[w_arb_idx][AXI_ID_IN-1:0];
        bresp_o  = bresp_i[w_arb_idx];
        buser_o  = buser_i[w_arb_idx];
        if (!w_op) begin
            bvalid_o = 1'b1;
            bid_o    = w_q_head[QE_W-1:AXI_USER_W];
            bresp_o  = ERR_RESP;
            buser_o  = w_q_head[AXI_USER_W-1:0];
        end
        if (!rst_n) begin
            bvalid_o = 1'b0;
        end
    end

    assign bready_o            = (w_op && rst_n && bready_i) ? w_arb_grant : '0;
    assign error_gnt_o         = w_q_push && rst_n;
    assign error_full_o        = w_q_full;
    assign full_counter_o      = w_cnt_full;
    assign outstanding_trans_o = !w_cnt_zero;

endmodule

// File: tb/tb_axi_b_allocator_rr.sv
// Bench for axi_b_allocator_rr: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based behavioural model.
module tb_axi_b_allocator_rr;

    localparam int N   = 4;
    localparam int UW  = 6;
    localparam int IDI = 16;
    localparam int IDO = 19;
    localparam int CW  = 2;
    localparam int ED  = 4;
    localparam int QW  = IDI + UW;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0][IDO-1:0] bid_i;
    logic [N-1:0][1:0]     bresp_i;
    logic [N-1:0][UW-1:0]  buser_i;
    logic [N-1:0]          bvalid_i;
    logic [N-1:0]          bready_o;
    logic [IDI-1:0]        bid_o;
    logic [1:0]            bresp_o;
    logic [UW-1:0]         buser_o;
    logic                  bvalid_o;
    logic                  bready_i;
    logic                  incr_req_i;
    logic                  full_counter_o;
    logic                  outstanding_trans_o;
    logic                  error_req_i;
    logic [IDI-1:0]        error_id_i;
    logic [UW-1:0]         error_user_i;
    logic                  error_gnt_o;
    logic                  error_full_o;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int              m_cnt;
    int              m_ptr;
    int              m_hold_idx;
    bit              m_hold;
    bit              m_err;
    logic [QW-1:0]   m_q[$];
    bit              last_hs;
    int              last_w;

    // Outputs captured just before the edge of the most recent cycle
    logic [IDI-1:0]  obs_bid;
    logic [1:0]      obs_resp;
    logic [UW-1:0]   obs_user;
    logic            obs_valid;
    logic [N-1:0]    obs_bready;
    logic            obs_gnt;
    logic            obs_full;
    logic            obs_fullc;
    logic            obs_out;

    always #5 clk = ~clk;

    axi_b_allocator_rr #(
        .AXI_USER_W  (UW),
        .N_INIT_PORT (N),
        .AXI_ID_IN   (IDI),
        .AXI_ID_OUT  (IDO),
        .CNT_W       (CW),
        .ERR_DEPTH   (ED),
        .ERR_RESP    (2'b11)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bid_i               (bid_i),
        .bresp_i             (bresp_i),
        .buser_i             (buser_i),
        .bvalid_i            (bvalid_i),
        .bready_o            (bready_o),
        .bid_o               (bid_o),
        .bresp_o             (bresp_o),
        .buser_o             (buser_o),
        .bvalid_o            (bvalid_o),
        .bready_i            (bready_i),
        .incr_req_i          (incr_req_i),
        .full_counter_o      (full_counter_o),
        .outstanding_trans_o (outstanding_trans_o),
        .error_req_i         (error_req_i),
        .error_id_i          (error_id_i),
        .error_user_i        (error_user_i),
        .error_gnt_o         (error_gnt_o),
        .error_full_o        (error_full_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_cnt = 0;
        m_ptr = 0;
        m_hold = 1'b0;
        m_hold_idx = 0;
        m_err = 1'b0;
        m_q.delete();
        last_hs = 1'b0;
        last_w = 0;
    endtask

    task automatic idle();
        bvalid_i = '0;
        bready_i = 1'b0;
        incr_req_i = 1'b0;
        error_req_i = 1'b0;
    endtask

    task automatic drop_if_hs();
        if (last_hs) bvalid_i[last_w] = 1'b0;
    endtask

    task automatic set_port(input int p, input logic [IDO-1:0] id, input logic [1:0] resp, input logic [UW-1:0] user);
        bvalid_i[p] = 1'b1;
        bid_i[p] = id;
        bresp_i[p] = resp;
        buser_i[p] = user;
    endtask

    // One clock cycle: predict and check outputs for the current inputs,
    // then advance the model across the rising edge.
    task automatic cycle();
        int w;
        bit v, hs, pop, gnt, nerr, nhold;
        int nhold_idx;
        logic [N-1:0] rdy;
        logic [QW-1:0] head;
        #1;
        obs_bid = bid_o; obs_resp = bresp_o; obs_user = buser_o; obs_valid = bvalid_o;
        obs_bready = bready_o; obs_gnt = error_gnt_o; obs_full = error_full_o;
        obs_fullc = full_counter_o; obs_out = outstanding_trans_o;
        w = 0;
        v = 1'b0;
        if (m_err) begin
            v = 1'b1;
        end else if (m_hold) begin
            w = m_hold_idx;
            v = bvalid_i[w];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (bvalid_i[(m_ptr + k) % N]) begin
                    w = (m_ptr + k) % N;
                    v = 1'b1;
                end
            end
        end
        gnt = error_req_i && (m_q.size() < ED);
        chk("bvalid_o", 32'(bvalid_o), 32'(v));
        if (m_err) begin
            head = m_q[0];
            chk("err_bid", 32'(bid_o), 32'(head[QW-1:UW]));
            chk("err_bresp", 32'(bresp_o), 32'd3);
            chk("err_buser", 32'(buser_o), 32'(head[UW-1:0]));
            chk("err_bready_o", 32'(bready_o), 32'd0);
        end else begin
            rdy = (v && bready_i) ? (N'(1) << w) : '0;
            chk("bready_o", 32'(bready_o), 32'(rdy));
            if (v) begin
                chk("bid_o", 32'(bid_o), 32'(bid_i[w][IDI-1:0]));
                chk("bresp_o", 32'(bresp_o), 32'(bresp_i[w]));
                chk("buser_o", 32'(buser_o), 32'(buser_i[w]));
            end
        end
        chk("error_gnt_o", 32'(error_gnt_o), 32'(gnt));
        chk("error_full_o", 32'(error_full_o), 32'(m_q.size() == ED));
        chk("full_counter_o", 32'(full_counter_o), 32'(m_cnt == CMAX));
        chk("outstanding_o", 32'(outstanding_trans_o), 32'(m_cnt != 0));
        @(posedge clk);
        hs = !m_err && v && bready_i;
        pop = m_err && bready_i;
        nerr = m_err;
        nhold = m_hold;
        nhold_idx = m_hold_idx;
        if (m_err) begin
            if (pop) begin
                void'(m_q.pop_front());
                nerr = (m_q.size() > 0) && (m_cnt == 0);
            end
        end else begin
            if (m_q.size() > 0 && m_cnt == 0 && !m_hold && !v) nerr = 1'b1;
            if (hs) begin
                nhold = 1'b0;
                m_ptr = (w + 1) % N;
            end else if (v) begin
                nhold = 1'b1;
                nhold_idx = w;
            end
        end
        if (incr_req_i && !hs && m_cnt < CMAX) m_cnt++;
        else if (hs && !incr_req_i && m_cnt > 0) m_cnt--;
        if (gnt) m_q.push_back({error_id_i, error_user_i});
        m_err = nerr;
        m_hold = nhold;
        m_hold_idx = nhold_idx;
        last_hs = hs;
        last_w = w;
    endtask

    initial begin
        bid_i = '0;
        bresp_i = '0;
        buser_i = '0;
        error_id_i = '0;
        error_user_i = '0;
        reset_model();

        // Reset with busy inputs: every output must stay quiet
        rst_n = 1'b0;
        bvalid_i = '1;
        bready_i = 1'b1;
        incr_req_i = 1'b1;
        error_req_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bvalid", 32'(bvalid_o), 32'd0);
        chk("rst_bready", 32'(bready_o), 32'd0);
        chk("rst_gnt", 32'(error_gnt_o), 32'd0);
        chk("rst_full", 32'(error_full_o), 32'd0);
        chk("rst_fullc", 32'(full_counter_o), 32'd0);
        chk("rst_outst", 32'(outstanding_trans_o), 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        cycle();

        // Round-robin order from pointer 0 with ports 1 and 3 requesting
        @(negedge clk);
        set_port(1, 19'h00011, 2'b00, 6'h01);
        set_port(3, 19'h00033, 2'b01, 6'h03);
        bready_i = 1'b1;
        cycle();
        chk("rr_first", 32'(obs_bid), 32'h11);
        @(negedge clk); drop_if_hs(); cycle();
        chk("rr_second", 32'(obs_bid), 32'h33);
        @(negedge clk); drop_if_hs();
        set_port(0, 19'h000A0, 2'b10, 6'h0A);
        set_port(2, 19'h400C2, 2'b00, 6'h0C);
        bready_i = 1'b0;
        cycle();
        chk("rr_ptr_wrapped", 32'(obs_bid), 32'hA0);
        @(negedge clk); bready_i = 1'b1; cycle();
        chk("rr_port0_hs", 32'(obs_bready), 32'b0001);

        // Port 2 stalls five cycles; port 0 arrives mid-stall
        @(negedge clk); drop_if_hs(); bready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) set_port(0, 19'h000A5, 2'b00, 6'h15);
            cycle();
            chk("hold_bid", 32'(obs_bid), 32'hC2);
            @(negedge clk);
        end
        bready_i = 1'b1;
        cycle();
        chk("hold_release", 32'(obs_bid), 32'hC2);
        @(negedge clk); drop_if_hs(); cycle();
        chk("after_hold", 32'(obs_bid), 32'hA5);

        // Counter saturation and cancelling increment/decrement
        @(negedge clk); drop_if_hs(); idle();
        incr_req_i = 1'b1;
        repeat (4) begin cycle(); @(negedge clk); end
        set_port(1, 19'h00077, 2'b00, 6'h07);
        bready_i = 1'b1;
        cycle();
        chk("sat_full_before", 32'(obs_fullc), 32'd1);
        @(negedge clk); drop_if_hs(); idle(); cycle();
        chk("sat_full_after", 32'(obs_fullc), 32'd1);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk); drop_if_hs();
            set_port(p, IDO'(32'h200 + p), 2'b00, UW'(p));
            bready_i = 1'b1;
            cycle();
        end
        @(negedge clk); drop_if_hs(); idle(); cycle();
        chk("drained", 32'(obs_out), 32'd0);

        // Error waits for three outstanding writes to complete
        @(negedge clk); incr_req_i = 1'b1;
        repeat (3) begin cycle(); @(negedge clk); end
        incr_req_i = 1'b0;
        error_req_i = 1'b1; error_id_i = 16'h0005; error_user_i = 6'h2A;
        cycle();
        chk("err34_gnt", 32'(obs_gnt), 32'd1);
        @(negedge clk); error_req_i = 1'b0; cycle();
        chk("err34_wait", 32'(obs_valid), 32'd0);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk); drop_if_hs();
            set_port(p, IDO'(32'h300 + p), 2'b00, UW'(p + 8));
            bready_i = 1'b1;
            cycle();
            chk("err34_real_resp", 32'(obs_resp), 32'd0);
        end
        @(negedge clk); drop_if_hs(); idle(); cycle();
        chk("err34_switch", 32'(obs_valid), 32'd0);
        @(negedge clk); bready_i = 1'b1; cycle();
        chk("err34_valid", 32'(obs_valid), 32'd1);
        chk("err34_resp", 32'(obs_resp), 32'd3);
        chk("err34_id", 32'(obs_bid), 32'h5);
        chk("err34_user", 32'(obs_user), 32'h2A);

        // Five error pushes into a four-entry queue, then drain in order
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle();
            error_req_i = 1'b1; error_id_i = IDI'(32'h10 + i); error_user_i = UW'(i);
            cycle();
            chk("err35_gnt", 32'(obs_gnt), 32'(i < 4));
            if (i == 4) chk("err35_full", 32'(obs_full), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); bready_i = 1'b1;
            cycle();
            chk("err35_valid", 32'(obs_valid), 32'd1);
            chk("err35_order", 32'(obs_bid), 32'h10 + 32'(i));
        end
        @(negedge clk); idle(); cycle();
        chk("err35_done", 32'(obs_valid), 32'd0);
        chk("err35_notfull", 32'(obs_full), 32'd0);

        // Reset in the middle of an error response
        @(negedge clk);
        error_req_i = 1'b1; error_id_i = 16'h003C; error_user_i = 6'h15;
        cycle();
        @(negedge clk); idle(); cycle();
        @(negedge clk); cycle();
        chk("err37_active", 32'(obs_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("err37_drop", 32'(bvalid_o), 32'd0);
        chk("err37_bready", 32'(bready_o), 32'd0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("err37_empty", 32'(obs_full), 32'd0);
        @(negedge clk); cycle();
        chk("err37_no_resp", 32'(obs_valid), 32'd0);

        // Random traffic obeying AXI valid/ready stability
        for (int s = 0; s < 1500; s++) begin
            @(negedge clk);
            drop_if_hs();
            for (int i = 0; i < N; i++) begin
                if (!bvalid_i[i] && $urandom_range(0, 3) == 0) begin
                    set_port(i, IDO'($urandom), 2'($urandom), UW'($urandom));
                end
            end
            bready_i = ($urandom_range(0, 3) != 0);
            incr_req_i = ($urandom_range(0, 2) == 0);
            error_req_i = ($urandom_range(0, 7) == 0);
            error_id_i = IDI'($urandom);
            error_user_i = UW'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
